// File: rtl/input_debouncer_if.sv
// Pin-side bundle for input_debouncer: raw board inputs in, conditioned
// levels and single-cycle edge strobes out.
interface input_debouncer_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] level_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;

  // master: whoever owns the pins and consumes the clean controls.
  modport master (
    output raw_in,
    input  level_out,
    input  rise_pulse,
    input  fall_pulse
  );

  // slave: the debouncer itself.
  modport slave (
    input  raw_in,
    output level_out,
    output rise_pulse,
    output fall_pulse
  );
endinterface : input_debouncer_if

// File: rtl/input_debouncer.sv
// Per-channel input conditioner: synchroniser into sys_clk, stable-count
// debounce filter, clean level and registered single-cycle rise/fall strobes.
module input_debouncer #(
  parameter int               WIDTH           = 3,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 270000,
  parameter logic [WIDTH-1:0] INVERT          = '0
) (
  input  logic              sys_clk,
  input  logic              rst,
  input_debouncer_if.slave  bus
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] flip;

  // Polarity is normalised before the first flop, so everything downstream
  // (including the reset value 0) means "inactive" regardless of INVERT.
  // NOTE: the synchroniser stages are reset too; otherwise an active-low idle
  // input would look like a fresh edge coming out of reset.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what turns this loop into a shift chain.
      sync_q[0] <= bus.raw_in ^ INVERT;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A channel flips when it has disagreed with the level for DEBOUNCE_CYCLES
  // consecutive edges, the last of which is this one.
  // NOTE: flip gets a default before the loop so no bit can infer a latch.
  always_comb begin
    flip = '0;
    for (int i = 0; i < WIDTH; i++) begin
      flip[i] = (s[i] != level_q[i]) && (cnt_q[i] == CNT_MAX);
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (flip[i]) begin
          cnt_q[i]   <= '0;
          level_q[i] <= s[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end
      end
      // Strobes are registered alongside the level so they rise on the very
      // edge where level_out flips and last exactly one cycle.
      rise_q <= flip & s;
      fall_q <= flip & ~s;
    end
  end

  assign bus.level_out  = level_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;

endmodule : input_debouncer

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: pulse events are scoreboarded by edge
// number, levels are checked directly at chosen points.
module tb_input_debouncer;

  localparam int W  = 3;
  localparam int DC = 8;
  localparam int LAT = 2 + DC;

  typedef struct {
    int         cyc;
    logic [2:0] rise;
    logic [2:0] fall;
    logic [2:0] level;
  } ev_t;

  logic sys_clk = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  ev_t exp_a[$];
  ev_t exp_b[$];

  input_debouncer_if #(.WIDTH(W)) if_a ();
  input_debouncer_if #(.WIDTH(W)) if_b ();

  input_debouncer #(
    .WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DC), .INVERT(3'b000)
  ) dut_a (
    .sys_clk(sys_clk), .rst(rst), .bus(if_a)
  );

  input_debouncer #(
    .WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DC), .INVERT(3'b010)
  ) dut_b (
    .sys_clk(sys_clk), .rst(rst), .bus(if_b)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cmp_ev(input string tag, input ev_t ev,
                        input logic [2:0] rise, input logic [2:0] fall, input logic [2:0] level);
    chk({tag, ".cyc"},   32'(cyc), 32'(ev.cyc));
    chk({tag, ".rise"},  32'(rise), 32'(ev.rise));
    chk({tag, ".fall"},  32'(fall), 32'(ev.fall));
    chk({tag, ".level"}, 32'(level), 32'(ev.level));
  endtask

  // Any strobe must match the oldest outstanding expectation.
  always @(negedge sys_clk) begin
    if (|if_a.rise_pulse || |if_a.fall_pulse) begin
      chk("a.expected_pulse", 32'(exp_a.size() != 0), 32'd1);
      if (exp_a.size() != 0)
        cmp_ev("a.ev", exp_a.pop_front(), if_a.rise_pulse, if_a.fall_pulse, if_a.level_out);
    end
    if (|if_b.rise_pulse || |if_b.fall_pulse) begin
      chk("b.expected_pulse", 32'(exp_b.size() != 0), 32'd1);
      if (exp_b.size() != 0)
        cmp_ev("b.ev", exp_b.pop_front(), if_b.rise_pulse, if_b.fall_pulse, if_b.level_out);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Called at a negedge right after driving raw_in: the event lands LAT edges on.
  task automatic push_a(input logic [2:0] rise, input logic [2:0] fall, input logic [2:0] level);
    ev_t ev;
    ev.cyc = cyc + LAT; ev.rise = rise; ev.fall = fall; ev.level = level;
    exp_a.push_back(ev);
  endtask

  task automatic push_b(input logic [2:0] rise, input logic [2:0] fall, input logic [2:0] level);
    ev_t ev;
    ev.cyc = cyc + LAT; ev.rise = rise; ev.fall = fall; ev.level = level;
    exp_b.push_back(ev);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && (exp_a.size() != 0 || exp_b.size() != 0); i++)
      @(negedge sys_clk);
    chk({tag, ".a_pending"}, 32'(exp_a.size()), 32'd0);
    chk({tag, ".b_pending"}, 32'(exp_b.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    if_a.raw_in = 3'b000;
    if_b.raw_in = 3'b010;
    #1;
    chk("reset.level_a", 32'(if_a.level_out), 32'd0);
    chk("reset.rise_a",  32'(if_a.rise_pulse), 32'd0);
    chk("reset.fall_a",  32'(if_a.fall_pulse), 32'd0);
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(3);
    chk("post_reset.level_a", 32'(if_a.level_out), 32'd0);
    chk("post_reset.level_b", 32'(if_b.level_out), 32'd0);

    // 1: clean press / release on channel 1
    if_a.raw_in = 3'b010; push_a(3'b010, 3'b000, 3'b010);
    wait_cycles(LAT - 1);
    chk("press.level_before", 32'(if_a.level_out), 32'd0);
    wait_cycles(20 - (LAT - 1));
    chk("press.level_held", 32'(if_a.level_out), 32'b010);
    if_a.raw_in = 3'b000; push_a(3'b000, 3'b010, 3'b000);
    wait_cycles(12);
    drain("press");

    // 2: bounce on channel 0, then held high
    for (int k = 0; k < 10; k++) begin
      if_a.raw_in[0] = ~if_a.raw_in[0];
      wait_cycles(3);
    end
    chk("bounce.level", 32'(if_a.level_out), 32'd0);
    if_a.raw_in[0] = 1'b1; push_a(3'b001, 3'b000, 3'b001);
    wait_cycles(15);
    chk("bounce.level_held", 32'(if_a.level_out), 32'b001);
    if_a.raw_in[0] = 1'b0; push_a(3'b000, 3'b001, 3'b000);
    wait_cycles(12);
    drain("bounce");

    // 3: 7-cycle glitch is swallowed, 8-cycle pulse is accepted
    if_a.raw_in[2] = 1'b1;
    wait_cycles(7);
    if_a.raw_in[2] = 1'b0;
    wait_cycles(15);
    chk("glitch7.level", 32'(if_a.level_out), 32'd0);
    if_a.raw_in[2] = 1'b1; push_a(3'b100, 3'b000, 3'b100);
    wait_cycles(8);
    if_a.raw_in[2] = 1'b0; push_a(3'b000, 3'b100, 3'b000);
    wait_cycles(12);
    chk("glitch8.level_back", 32'(if_a.level_out), 32'd0);
    drain("glitch");

    // 4: all channels together
    if_a.raw_in = 3'b111; push_a(3'b111, 3'b000, 3'b111);
    wait_cycles(12);
    chk("multi.level", 32'(if_a.level_out), 32'b111);
    if_a.raw_in = 3'b000; push_a(3'b000, 3'b111, 3'b000);
    wait_cycles(12);
    drain("multi");

    // 5: idle active-low input through reset, then pressed
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(50);
    chk("actlow.idle_level", 32'(if_b.level_out), 32'd0);
    if_b.raw_in = 3'b000; push_b(3'b010, 3'b000, 3'b010);
    wait_cycles(12);
    chk("actlow.level", 32'(if_b.level_out), 32'b010);
    if_b.raw_in = 3'b010; push_b(3'b000, 3'b010, 3'b000);
    wait_cycles(12);
    drain("actlow");

    // 6: async reset mid-count with another channel already high
    if_a.raw_in = 3'b010; push_a(3'b010, 3'b000, 3'b010);
    wait_cycles(12);
    drain("areset.setup");
    if_a.raw_in = 3'b011;
    wait_cycles(7);
    #2 rst = 1'b1;
    #1;
    chk("areset.level_now", 32'(if_a.level_out), 32'd0);
    chk("areset.rise_now",  32'(if_a.rise_pulse), 32'd0);
    wait_cycles(2);
    rst = 1'b0; push_a(3'b011, 3'b000, 3'b011);
    wait_cycles(LAT - 1);
    chk("areset.level_early", 32'(if_a.level_out), 32'd0);
    wait_cycles(3);
    chk("areset.level", 32'(if_a.level_out), 32'b011);
    if_a.raw_in = 3'b000; push_a(3'b000, 3'b011, 3'b000);
    wait_cycles(12);
    drain("areset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_input_debouncer
